// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a valid/ready instruction-memory request port and a
// prefetch queue in front of decode. Requests are only issued when a queue
// slot is guaranteed for the response. Responses that were still in flight
// when a redirect happened are counted and silently discarded.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

`ifndef PC_RESET_VALUE
`define PC_RESET_VALUE 32'h0000_0000
`endif

package fetch_pkg;

    typedef struct packed {
        logic [`INSTR_WIDTH-1:0] instr;
        logic [`DATA_WIDTH-1:0]  pc;
        logic [`DATA_WIDTH-1:0]  pc_plus_4;
    } if_id_data_t;

endpackage

module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int                     FIFO_DEPTH          = 4,
    parameter logic [`DATA_WIDTH-1:0] PC_INIT_VALUE_PARAM = `PC_RESET_VALUE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_f_i,
    input  logic                    pc_src_e_i,
    input  logic [`DATA_WIDTH-1:0]  pc_target_e_i,
    output logic                    imem_req_valid_o,
    input  logic                    imem_req_ready_i,
    output logic [`DATA_WIDTH-1:0]  imem_req_addr_o,
    input  logic                    imem_rsp_valid_i,
    input  logic [`INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                    if_id_valid_o,
    output if_id_data_t             if_id_data_o
);

    localparam int DW    = `DATA_WIDTH;
    localparam int IW    = `INSTR_WIDTH;
    // Slot index width; pointers carry one extra wrap bit so that a full
    // queue and an empty queue are distinguishable by subtraction.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IW-1:0]    NOP_INSTR = IW'(32'h0000_0013);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0]    PC_STEP   = DW'(4);
    localparam logic [DW-1:0]    ALIGN_MSK = ~DW'(3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Control state (reset)
    logic [DW-1:0]         fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      head_q, head_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      drop_count_q, drop_count_d;
    logic [FIFO_DEPTH-1:0] filled_q, filled_d;

    // Slot payload (not reset; qualified by filled_q)
    logic [DW-1:0] slot_pc_q    [FIFO_DEPTH];
    logic [DW-1:0] slot_pc_d    [FIFO_DEPTH];
    logic [IW-1:0] slot_instr_q [FIFO_DEPTH];
    logic [IW-1:0] slot_instr_d [FIFO_DEPTH];

    // Derived occupancy and handshake terms
    logic [CNT_W-1:0] alloc_count;
    logic [CNT_W-1:0] unfilled_count;
    logic [CNT_W:0]   credit_sum;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] tail_idx;
    logic             head_valid;
    logic             req_valid;
    logic             req_fire;
    logic             deq;

    assign head_idx       = head_q[PTR_W-1:0];
    assign fill_idx       = fill_q[PTR_W-1:0];
    assign tail_idx       = tail_q[PTR_W-1:0];

    // Slots reserved (tail..head) and reserved slots still waiting for data.
    assign alloc_count    = tail_q - head_q;
    assign unfilled_count = tail_q - fill_q;

    // A request may only leave when both the live stream and the stale
    // responses still owed have room; never during a redirect cycle.
    assign credit_sum     = {1'b0, alloc_count} + {1'b0, drop_count_q};
    assign req_valid      = (credit_sum < DEPTH_EXT) && !pc_src_e_i;
    assign req_fire       = req_valid && imem_req_ready_i;

    assign head_valid     = filled_q[head_idx];
    assign deq            = head_valid && !stall_f_i && !pc_src_e_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign if_id_valid_o    = head_valid;

    // Next-state: allocation, response fill/discard, dequeue, redirect flush
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        head_d       = head_q;
        fill_d       = fill_q;
        tail_d       = tail_q;
        drop_count_d = drop_count_q;
        filled_d     = filled_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;

        if (pc_src_e_i) begin
            // Every slot is flushed. Any reserved-but-unfilled slot still has
            // a response on its way, which now becomes a stale one to drop;
            // a response arriving this very cycle is one of them, consumed now.
            filled_d     = '0;
            head_d       = tail_q;
            fill_d       = tail_q;
            fetch_pc_d   = pc_target_e_i & ALIGN_MSK;
            drop_count_d = drop_count_q + unfilled_count - CNT_W'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                slot_pc_d[tail_idx] = fetch_pc_q;
                filled_d[tail_idx]  = 1'b0;
                tail_d              = tail_q + CNT_ONE;
                fetch_pc_d          = fetch_pc_q + PC_STEP;
            end

            if (imem_rsp_valid_i) begin
                if (drop_count_q != '0) begin
                    drop_count_d = drop_count_q - CNT_ONE;
                end else begin
                    slot_instr_d[fill_idx] = imem_rsp_data_i;
                    filled_d[fill_idx]     = 1'b1;
                    fill_d                 = fill_q + CNT_ONE;
                end
            end

            if (deq) begin
                filled_d[head_idx] = 1'b0;
                head_d             = head_q + CNT_ONE;
            end
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q   <= PC_INIT_VALUE_PARAM;
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            drop_count_q <= '0;
            filled_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            head_q       <= head_d;
            fill_q       <= fill_d;
            tail_q       <= tail_d;
            drop_count_q <= drop_count_d;
            filled_q     <= filled_d;
        end
    end

    // Slot payload storage; contents are meaningless until the filled flag is set
    always_ff @(posedge clk) begin
        slot_pc_q    <= slot_pc_d;
        slot_instr_q <= slot_instr_d;
    end

    // Head entry to decode, or a NOP bubble when the head is not filled
    always_comb begin
        if_id_data_o.instr     = NOP_INSTR;
        if_id_data_o.pc        = '0;
        if_id_data_o.pc_plus_4 = PC_STEP;
        if (head_valid) begin
            if_id_data_o.instr     = slot_instr_q[head_idx];
            if_id_data_o.pc        = slot_pc_q[head_idx];
            if_id_data_o.pc_plus_4 = slot_pc_q[head_idx] + PC_STEP;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a small in-order,
// fixed-latency instruction memory model. Memory data for address a is
// 32'hC0DE_0000 + a so every expected instruction is easy to derive by hand.

module tb_fetch_prefetch_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'hC0DE_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        if_valid;
    logic [95:0] if_data;

    int n_assert;
    int n_fail;
    int cyc;
    int lat;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    fetch_prefetch_queue #(
        .FIFO_DEPTH          (4),
        .PC_INIT_VALUE_PARAM (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_f_i        (stall_f),
        .pc_src_e_i       (pc_src_e),
        .pc_target_e_i    (pc_target_e),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .if_id_valid_o    (if_valid),
        .if_id_data_o     (if_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
        check({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v});
        check({tag, "_instr"}, if_data[95:64], instr);
        check({tag, "_pc"},    if_data[63:32], pc);
        check({tag, "_pc4"},   if_data[31:0],  pc + 32'd4);
    endtask

    // One clock: capture the handshake, advance, then drive this cycle's response.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        logic        rs;
        #1;
        fire = req_valid && req_ready;
        a    = req_addr;
        rs   = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rs) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (fire) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc - 1 + lat);
        end
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        if (rs && mq_due.size() > 0) begin
            if (mq_due[0] <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = BASE + mq_addr[0];
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int l);
        lat         = l;
        rst_n       = 1'b0;
        stall_f     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'h0;
        req_ready   = 1'b1;
        tick();
        tick();
        #1;
        chk_head("rst", 1'b0, 32'h0, NOP);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;

        // Streaming at L=1: one instruction per cycle, two cycles after first request
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t1_rv", {31'b0, req_valid}, 32'd1);
            check("t1_addr", req_addr, 32'(4 * k));
            if (k < 2) chk_head("t1_head", 1'b0, 32'h0, NOP);
            else       chk_head("t1_head", 1'b1, 32'(4 * (k - 2)), BASE + 32'(4 * (k - 2)));
            tick();
        end

        // Stall held: exactly four requests, head parked at pc 0, then drain
        do_reset(1);
        stall_f = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 7) stall_f = 1'b0;
            #1;
            if (k < 4) begin
                check("t2_rv", {31'b0, req_valid}, 32'd1);
                check("t2_addr", req_addr, 32'(4 * k));
            end else if (k < 8) begin
                check("t2_rv_full", {31'b0, req_valid}, 32'd0);
            end else if (k == 8) begin
                check("t2_rv_resume", {31'b0, req_valid}, 32'd1);
                check("t2_addr_resume", req_addr, 32'h10);
            end
            if (k < 2)      chk_head("t2_head", 1'b0, 32'h0, NOP);
            else if (k < 7) chk_head("t2_hold", 1'b1, 32'h0, BASE);
            else            chk_head("t2_drain", 1'b1, 32'(4 * (k - 7)), BASE + 32'(4 * (k - 7)));
            tick();
        end

        // L=3, redirect with two requests unfilled: both late responses discarded
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            req_ready   = (k != 2);
            pc_src_e    = (k == 2);
            pc_target_e = 32'h0000_0100;
            #1;
            case (k)
                0: check("t3_addr0", req_addr, 32'h0);
                1: check("t3_addr1", req_addr, 32'h4);
                2: check("t3_rv_redir", {31'b0, req_valid}, 32'd0);
                3: check("t3_addr_tgt", req_addr, 32'h100);
                4: check("t3_addr_tgt4", req_addr, 32'h104);
                5: check("t3_addr_tgt8", req_addr, 32'h108);
                6: check("t3_rv6", {31'b0, req_valid}, 32'd1);
                default: check("t3_rv_full", {31'b0, req_valid}, 32'd0);
            endcase
            if (k < 7) chk_head("t3_head", 1'b0, 32'h0, NOP);
            else       chk_head("t3_first", 1'b1, 32'h100, BASE + 32'h100);
            tick();
        end
        pc_src_e = 1'b0;

        // Redirect coinciding with a response and a dequeue-eligible head
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            pc_src_e    = (k == 2);
            pc_target_e = 32'h0000_0100;
            #1;
            case (k)
                0: begin check("t4_addr0", req_addr, 32'h0); chk_head("t4_h0", 1'b0, 32'h0, NOP); end
                1: begin check("t4_addr1", req_addr, 32'h4); chk_head("t4_h1", 1'b0, 32'h0, NOP); end
                2: begin
                    check("t4_rv_redir", {31'b0, req_valid}, 32'd0);
                    check("t4_rsp_same", {31'b0, rsp_valid}, 32'd1);
                    chk_head("t4_h2", 1'b1, 32'h0, BASE);
                end
                3: begin
                    check("t4_rv3", {31'b0, req_valid}, 32'd1);
                    check("t4_addr3", req_addr, 32'h100);
                    chk_head("t4_flushed", 1'b0, 32'h0, NOP);
                end
                4: chk_head("t4_h4", 1'b0, 32'h0, NOP);
                default: chk_head("t4_tgt", 1'b1, 32'h100, BASE + 32'h100);
            endcase
            tick();
        end
        pc_src_e = 1'b0;

        // Target alignment and program-counter wrap
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            pc_src_e    = (k == 0) || (k == 2);
            pc_target_e = (k == 0) ? 32'h0000_0203 : 32'hFFFF_FFFF;
            #1;
            case (k)
                0: check("t5_rv0", {31'b0, req_valid}, 32'd0);
                1: check("t5_align", req_addr, 32'h200);
                2: check("t5_rv2", {31'b0, req_valid}, 32'd0);
                3: check("t5_top", req_addr, 32'hFFFF_FFFC);
                4: check("t5_wrap", req_addr, 32'h0);
                default: chk_head("t5_head", 1'b1, 32'hFFFF_FFFC, BASE + 32'hFFFF_FFFC);
            endcase
            tick();
        end
        pc_src_e = 1'b0;

        // Memory not ready for 5 cycles: address held, output drains to bubble
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            req_ready = (k < 2) || (k == 7);
            #1;
            check("t6_rv", {31'b0, req_valid}, 32'd1);
            if (k < 2) check("t6_addr", req_addr, 32'(4 * k));
            else       check("t6_hold", req_addr, 32'h8);
            if (k < 2)       chk_head("t6_head", 1'b0, 32'h0, NOP);
            else if (k < 4)  chk_head("t6_out", 1'b1, 32'(4 * (k - 2)), BASE + 32'(4 * (k - 2)));
            else             chk_head("t6_bubble", 1'b0, 32'h0, NOP);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
